// File: rtl/musa_trace_buffer_if.sv
// Sample-capture and readout bus for musa_trace_buffer.
// The master side feeds samples and requests entries; the slave side is the buffer.
interface musa_trace_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_CH     = 8,
    parameter int TS_WIDTH   = 16
);
    localparam int EW = TS_WIDTH + NUM_CH + ADDR_WIDTH + DATA_WIDTH;

    logic                  valid_in;
    logic [NUM_CH-1:0]     evt_in;
    logic [ADDR_WIDTH-1:0] pc_in;
    logic [DATA_WIDTH-1:0] instr_in;
    logic                  rd_req;
    logic                  rd_valid;
    logic [EW-1:0]         rd_data;
    logic                  rd_last;

    modport master (
        output valid_in, evt_in, pc_in, instr_in, rd_req,
        input  rd_valid, rd_data, rd_last
    );
    modport slave (
        input  valid_in, evt_in, pc_in, instr_in, rd_req,
        output rd_valid, rd_data, rd_last
    );
endinterface

// File: rtl/musa_trace_buffer.sv
// Circular trace capture: masked-compare trigger, programmable post-trigger window,
// oldest-first readout of {ts, evt, pc, instr}.
module musa_trace_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int NUM_CH     = 8,
    parameter int TS_WIDTH   = 16,
    localparam int PW        = $clog2(DEPTH),
    localparam int EW        = TS_WIDTH + NUM_CH + ADDR_WIDTH + DATA_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_arm,
    input  logic [NUM_CH-1:0]  i_trig_mask,
    input  logic [NUM_CH-1:0]  i_trig_value,
    input  logic [PW-1:0]      i_post_count,
    musa_trace_buffer_if.slave bus,
    output logic [1:0]         o_state,
    output logic [PW:0]        o_entries,
    output logic [PW-1:0]      o_trig_pos,
    output logic               o_wrapped
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_POST = 2'd2, S_DONE = 2'd3} state_t;

    state_t              r_state;
    logic [TS_WIDTH-1:0] r_ts;
    logic [PW-1:0]       r_wr_ptr, r_rd_ptr, r_post_lat, r_post_rem, r_trig_pos;
    logic [PW:0]         r_entries, r_rd_left;
    logic                r_wrapped, r_rd_valid, r_rd_last;
    logic [EW-1:0]       r_rd_data;
    logic [EW-1:0]       r_mem [DEPTH];

    logic          w_capture, w_trig, w_full, w_wrapped_nxt, w_done, w_rd_fire;
    logic [PW:0]   w_ent_nxt;
    logic [PW-1:0] w_wr_ptr_nxt, w_trig_pos_nxt, w_rd_ptr_start;

    // arm wins over a same-cycle sample, so a sample alongside arm is dropped
    assign w_capture      = bus.valid_in && (r_state == S_ARMED || r_state == S_POST) && !i_arm;
    assign w_trig         = ((bus.evt_in ^ i_trig_value) & i_trig_mask) == '0;
    assign w_full         = r_entries == (PW+1)'(DEPTH);
    assign w_ent_nxt      = w_full ? r_entries : r_entries + 1'b1;
    assign w_wrapped_nxt  = r_wrapped | w_full;
    assign w_wr_ptr_nxt   = r_wr_ptr + 1'b1;
    // modulo-DEPTH arithmetic is exact here since entries-1-post lies in [0, DEPTH-1]
    assign w_trig_pos_nxt = w_ent_nxt[PW-1:0] - 1'b1 - r_post_lat;
    assign w_rd_ptr_start = w_wrapped_nxt ? w_wr_ptr_nxt : '0;
    assign w_done         = w_capture && ((r_state == S_ARMED && w_trig && r_post_lat == '0) ||
                                          (r_state == S_POST && r_post_rem == PW'(1)));
    assign w_rd_fire      = r_state == S_DONE && bus.rd_req && r_rd_left != '0 && !i_arm;

    assign o_state      = r_state;
    assign o_entries    = r_entries;
    assign o_trig_pos   = r_trig_pos;
    assign o_wrapped    = r_wrapped;
    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_data  = r_rd_data;
    assign bus.rd_last  = r_rd_last;

    always_ff @(posedge clk) begin
        if (!rst && w_capture)
            r_mem[r_wr_ptr] <= {r_ts, bus.evt_in, bus.pc_in, bus.instr_in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ts       <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_post_lat <= '0;
            r_post_rem <= '0;
            r_trig_pos <= '0;
            r_entries  <= '0;
            r_rd_left  <= '0;
            r_wrapped  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_ts       <= r_ts + 1'b1;
            r_rd_valid <= w_rd_fire;
            r_rd_last  <= w_rd_fire && r_rd_left == (PW+1)'(1);
            if (w_rd_fire) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_rd_left <= r_rd_left - 1'b1;
            end
            if (i_arm) begin
                // post_count is PW bits wide, so it can never exceed DEPTH-1
                r_state    <= S_ARMED;
                r_wr_ptr   <= '0;
                r_entries  <= '0;
                r_wrapped  <= 1'b0;
                r_post_lat <= i_post_count;
                r_trig_pos <= '0;
                r_rd_left  <= '0;
            end else begin
                if (w_capture) begin
                    r_wr_ptr  <= w_wr_ptr_nxt;
                    r_entries <= w_ent_nxt;
                    r_wrapped <= w_wrapped_nxt;
                end
                if (w_done) begin
                    r_state    <= S_DONE;
                    r_trig_pos <= w_trig_pos_nxt;
                    r_rd_ptr   <= w_rd_ptr_start;
                    r_rd_left  <= w_ent_nxt;
                end else begin
                    case (r_state)
                        S_ARMED: if (w_capture && w_trig) begin
                            r_state    <= S_POST;
                            r_post_rem <= r_post_lat;
                        end
                        S_POST:  if (w_capture) r_post_rem <= r_post_rem - 1'b1;
                        S_DONE:  if (r_rd_valid && r_rd_last) r_state <= S_IDLE;
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_musa_trace_buffer.sv
// Directed bench for musa_trace_buffer: one task per scenario, inline expected values.
module tb_musa_trace_buffer;
    logic       clk = 1'b0;
    logic       rst, arm;
    logic [7:0] tmask, tval;
    logic [5:0] post;
    logic [1:0] state;
    logic [6:0] entries;
    logic [5:0] tpos;
    logic       wrapped;
    int         n_cmp = 0;
    int         n_err = 0;

    musa_trace_buffer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_CH(8), .TS_WIDTH(16)) bus ();

    musa_trace_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(64), .NUM_CH(8), .TS_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .i_arm(arm), .i_trig_mask(tmask), .i_trig_value(tval),
        .i_post_count(post), .bus(bus), .o_state(state), .o_entries(entries),
        .o_trig_pos(tpos), .o_wrapped(wrapped)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_arm(input logic [7:0] m, input logic [7:0] v, input logic [5:0] p);
        tmask = m; tval = v; post = p; arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic send(input logic v, input logic [31:0] pc, input logic [7:0] e);
        bus.valid_in = v; bus.pc_in = pc; bus.instr_in = ~pc; bus.evt_in = e;
        tick();
        bus.valid_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            arm = 1'($urandom); bus.valid_in = 1'($urandom); bus.rd_req = 1'($urandom);
            bus.evt_in = 8'($urandom); bus.pc_in = $urandom; bus.instr_in = $urandom;
            tmask = 8'($urandom); tval = 8'($urandom); post = 6'($urandom);
            tick();
        end
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL reset_state got=%0d exp=0", state); end
        n_cmp++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid got=%b exp=0", bus.rd_valid); end
        n_cmp++; if (entries !== 7'd0) begin n_err++; $display("FAIL reset_entries got=%0d exp=0", entries); end
        n_cmp++; if (wrapped !== 1'b0) begin n_err++; $display("FAIL reset_wrapped got=%b exp=0", wrapped); end
        n_cmp++; if (bus.rd_data !== 88'd0) begin n_err++; $display("FAIL reset_rd_data got=%h exp=0", bus.rd_data); end
        n_cmp++; if (tpos !== 6'd0) begin n_err++; $display("FAIL reset_trig_pos got=%0d exp=0", tpos); end
        rst = 1'b0; arm = 1'b0; bus.valid_in = 1'b0; bus.rd_req = 1'b1;
        tick();
        bus.rd_req = 1'b0;
        n_cmp++; if (bus.rd_valid !== 1'b0 || state !== 2'd0) begin n_err++; $display("FAIL idle_rd_req got valid=%b state=%0d exp 0/0", bus.rd_valid, state); end
    endtask

    task automatic test_no_wrap();
        do_arm(8'h04, 8'h04, 6'd3);
        n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL nowrap_armed got=%0d exp=1", state); end
        for (int i = 0; i < 10; i++) begin
            send(1'b1, 32'(i), (i == 5) ? 8'h04 : 8'h00);
            if (i == 5) begin n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL nowrap_post got=%0d exp=2", state); end end
            if (i == 8) begin n_cmp++; if (state !== 2'd3) begin n_err++; $display("FAIL nowrap_done got=%0d exp=3", state); end end
        end
        n_cmp++; if (entries !== 7'd9) begin n_err++; $display("FAIL nowrap_entries got=%0d exp=9", entries); end
        n_cmp++; if (tpos !== 6'd5) begin n_err++; $display("FAIL nowrap_trig_pos got=%0d exp=5", tpos); end
        n_cmp++; if (wrapped !== 1'b0) begin n_err++; $display("FAIL nowrap_wrapped got=%b exp=0", wrapped); end
        bus.rd_req = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            n_cmp++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data[63:32] !== 32'(i) || bus.rd_data[31:0] !== ~32'(i) || bus.rd_last !== (i == 8)) begin
                n_err++; $display("FAIL nowrap_read%0d got v=%b pc=%0d last=%b exp v=1 pc=%0d last=%b", i, bus.rd_valid, bus.rd_data[63:32], bus.rd_last, i, i == 8);
            end
        end
        bus.rd_req = 1'b0;
        tick();
        n_cmp++; if (state !== 2'd0 || bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL nowrap_idle got state=%0d v=%b exp 0/0", state, bus.rd_valid); end
    endtask

    task automatic test_wrap();
        do_arm(8'h01, 8'h01, 6'd10);
        for (int i = 0; i <= 110; i++) send(1'b1, 32'(i), (i == 100) ? 8'h01 : 8'h00);
        n_cmp++; if (state !== 2'd3) begin n_err++; $display("FAIL wrap_done got=%0d exp=3", state); end
        n_cmp++; if (entries !== 7'd64) begin n_err++; $display("FAIL wrap_entries got=%0d exp=64", entries); end
        n_cmp++; if (wrapped !== 1'b1) begin n_err++; $display("FAIL wrap_wrapped got=%b exp=1", wrapped); end
        n_cmp++; if (tpos !== 6'd53) begin n_err++; $display("FAIL wrap_trig_pos got=%0d exp=53", tpos); end
        bus.rd_req = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tick();
            n_cmp++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data[63:32] !== 32'(47 + i) || bus.rd_last !== (i == 63)) begin
                n_err++; $display("FAIL wrap_read%0d got v=%b pc=%0d last=%b exp v=1 pc=%0d last=%b", i, bus.rd_valid, bus.rd_data[63:32], bus.rd_last, 47 + i, i == 63);
            end
        end
        bus.rd_req = 1'b0;
        tick();
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL wrap_idle got=%0d exp=0", state); end
    endtask

    task automatic test_gapped();
        do_arm(8'hFF, 8'h5A, 6'd0);
        send(1'b1, 32'd0, 8'h00);
        send(1'b0, 32'd99, 8'h5A);
        n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL gap0_invalid_trig got=%0d exp=1", state); end
        send(1'b1, 32'd1, 8'h5A);
        n_cmp++; if (state !== 2'd3) begin n_err++; $display("FAIL gap0_done got=%0d exp=3", state); end
        send(1'b1, 32'd2, 8'h5A);
        n_cmp++; if (entries !== 7'd2 || tpos !== 6'd1) begin n_err++; $display("FAIL gap0_window got ent=%0d pos=%0d exp 2/1", entries, tpos); end
        bus.rd_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data[63:32] !== 32'(i) || bus.rd_last !== (i == 1)) begin
                n_err++; $display("FAIL gap0_read%0d got v=%b pc=%0d last=%b exp v=1 pc=%0d last=%b", i, bus.rd_valid, bus.rd_data[63:32], bus.rd_last, i, i == 1);
            end
        end
        bus.rd_req = 1'b0;
        tick();

        do_arm(8'h80, 8'h80, 6'd4);
        send(1'b1, 32'd0, 8'h80);
        n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL gap4_post got=%0d exp=2", state); end
        for (int k = 1; k <= 4; k++) begin
            send(1'b0, 32'(100 + k), 8'h80);
            send(1'b1, 32'(k), 8'h80);
            n_cmp++;
            if (state !== ((k == 4) ? 2'd3 : 2'd2)) begin n_err++; $display("FAIL gap4_state%0d got=%0d exp=%0d", k, state, (k == 4) ? 3 : 2); end
        end
        n_cmp++; if (entries !== 7'd5 || tpos !== 6'd0) begin n_err++; $display("FAIL gap4_window got ent=%0d pos=%0d exp 5/0", entries, tpos); end
        for (int i = 0; i < 5; i++) begin
            bus.rd_req = 1'b1;
            tick();
            bus.rd_req = 1'b0;
            n_cmp++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data[63:32] !== 32'(i) || bus.rd_last !== (i == 4)) begin
                n_err++; $display("FAIL gap4_read%0d got v=%b pc=%0d last=%b exp v=1 pc=%0d last=%b", i, bus.rd_valid, bus.rd_data[63:32], bus.rd_last, i, i == 4);
            end
            tick();
            n_cmp++;
            if (bus.rd_valid !== 1'b0 || state !== ((i == 4) ? 2'd0 : 2'd3)) begin
                n_err++; $display("FAIL gap4_gap%0d got v=%b state=%0d exp v=0 state=%0d", i, bus.rd_valid, state, (i == 4) ? 0 : 3);
            end
        end
    endtask

    task automatic test_rearm();
        do_arm(8'h00, 8'h00, 6'd5);
        for (int i = 0; i < 8; i++) send(1'b1, 32'(i), 8'h00);
        n_cmp++; if (state !== 2'd3 || entries !== 7'd6 || tpos !== 6'd0) begin n_err++; $display("FAIL rearm_window got st=%0d ent=%0d pos=%0d exp 3/6/0", state, entries, tpos); end
        bus.rd_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data[63:32] !== 32'(i)) begin n_err++; $display("FAIL rearm_read%0d got v=%b pc=%0d exp v=1 pc=%0d", i, bus.rd_valid, bus.rd_data[63:32], i); end
        end
        tmask = 8'h00; tval = 8'h00; post = 6'd1; arm = 1'b1;
        tick();
        arm = 1'b0; bus.rd_req = 1'b0;
        n_cmp++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL rearm_no_valid got=%b exp=0", bus.rd_valid); end
        n_cmp++; if (state !== 2'd1 || entries !== 7'd0 || wrapped !== 1'b0) begin n_err++; $display("FAIL rearm_cleared got st=%0d ent=%0d wr=%b exp 1/0/0", state, entries, wrapped); end
        send(1'b1, 32'd20, 8'h00);
        send(1'b1, 32'd21, 8'h00);
        n_cmp++; if (state !== 2'd3 || entries !== 7'd2 || tpos !== 6'd0) begin n_err++; $display("FAIL rearm_new_window got st=%0d ent=%0d pos=%0d exp 3/2/0", state, entries, tpos); end
        bus.rd_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data[63:32] !== 32'(20 + i) || bus.rd_last !== (i == 1)) begin
                n_err++; $display("FAIL rearm_new_read%0d got v=%b pc=%0d last=%b exp v=1 pc=%0d last=%b", i, bus.rd_valid, bus.rd_data[63:32], bus.rd_last, 20 + i, i == 1);
            end
        end
        bus.rd_req = 1'b0;
        tick();
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL rearm_idle got=%0d exp=0", state); end
    endtask

    task automatic test_reset_mid_post();
        do_arm(8'h01, 8'h01, 6'd3);
        send(1'b1, 32'd7, 8'h01);
        n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL rstpost_in_post got=%0d exp=2", state); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (state !== 2'd0 || entries !== 7'd0) begin n_err++; $display("FAIL rstpost_idle got st=%0d ent=%0d exp 0/0", state, entries); end
        // ts is 0 after the reset edge, 1 in the cycle after arm: the sample carries ts=1
        do_arm(8'h00, 8'h00, 6'd0);
        send(1'b1, 32'd42, 8'h33);
        n_cmp++; if (state !== 2'd3) begin n_err++; $display("FAIL rstpost_done got=%0d exp=3", state); end
        bus.rd_req = 1'b1;
        tick();
        bus.rd_req = 1'b0;
        n_cmp++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data[87:72] !== 16'd1 || bus.rd_data[71:64] !== 8'h33 || bus.rd_data[63:32] !== 32'd42 || bus.rd_last !== 1'b1) begin
            n_err++; $display("FAIL rstpost_entry got v=%b ts=%0d evt=%h pc=%0d last=%b exp v=1 ts=1 evt=33 pc=42 last=1", bus.rd_valid, bus.rd_data[87:72], bus.rd_data[71:64], bus.rd_data[63:32], bus.rd_last);
        end
        tick();
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL rstpost_final_idle got=%0d exp=0", state); end
    endtask

    initial begin
        rst = 1'b0; arm = 1'b0; tmask = '0; tval = '0; post = '0;
        bus.valid_in = 1'b0; bus.evt_in = '0; bus.pc_in = '0; bus.instr_in = '0; bus.rd_req = 1'b0;
        test_reset();
        test_no_wrap();
        test_wrap();
        test_gapped();
        test_rearm();
        test_reset_mid_post();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/musa_trace_buffer.md
# musa_trace_buffer

Synthesisable, parametrised on-chip trace capture for the MUSA core. It samples a configurable number of datapath control-event channels per retired cycle, along with the instruction word and PC, into a circular buffer. Recording stops after a programmable number of post-trigger samples, and the window is then read out oldest-first over a simple request/valid port. It sits beside `dataPath`, fed from the same control taps the bench monitor uses (pc_src, mem_read, mem_write, push, pop, reg_write, …), so traces are available in hardware as well as in simulation.

## Interface
- DATA_WIDTH, 32: instruction word width.
- ADDR_WIDTH, 32: PC width.
- DEPTH, 64: buffer entries; must be a power of two and ≥4.
- NUM_CH, 8: event channels per sample.
- TS_WIDTH, 16: timestamp width.
- Derived: PW = $clog2(DEPTH); EW = TS_WIDTH+NUM_CH+ADDR_WIDTH+DATA_WIDTH.

Clocking and reset: one clock; reset is synchronous and active-high.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- arm  in  1  single-cycle pulse; clears pointers and starts capture.
- trig_mask  in  NUM_CH  channels that take part in the trigger compare.
- trig_value  in  NUM_CH  required value on the masked channels.
- post_count  in  PW  samples to keep after the trigger sample; latched on arm.
- valid_in  in  1  sample qualifier (one per retired cycle).
- evt_in  in  NUM_CH  event channel bits.
- pc_in  in  ADDR_WIDTH  PC of the sample.
- instr_in  in  DATA_WIDTH  instruction of the sample.
- rd_req  in  1  request the next readout entry.
- rd_valid  out  1  rd_data valid; a one-cycle pulse.
- rd_data  out  EW  packed entry {ts, evt, pc, instr}, with ts in the MSBs.
- rd_last  out  1  qualifies the final entry of the window.
- state  out  2  0=IDLE, 1=ARMED, 2=POST, 3=DONE.
- entries  out  PW+1  number of stored entries in the window (≤DEPTH).
- trig_pos  out  PW  readout index of the trigger sample.
- wrapped  out  1  pre-trigger history overwrote old entries.

## Operation
- **Timestamp:** free-running TS_WIDTH counter. It is cleared by rst, increments every cycle and wraps silently.
- **Sample:** one sample is captured per cycle in which valid_in=1 and state is ARMED or POST.
  - The sample is written at wr_ptr, and wr_ptr increments modulo DEPTH.
  - entries saturates at DEPTH.
  - wrapped sets when a write lands on an occupied slot.
- **Trigger condition:** valid_in && ((evt_in ^ trig_value) & trig_mask) == 0. A trig_mask of 0 triggers on the first valid sample.
- **IDLE:** no capture.
  - arm → ARMED with wr_ptr=0, entries=0, wrapped=0, and post_count latched (clamped to DEPTH-1).
- **ARMED:** capture continuously.
  - The trigger sample is stored and trig_pos is recorded.
  - Next state is POST, or DONE if the latched post_count=0.
- **POST:** capture until the latched post_count further valid samples are stored, then → DONE. Cycles with valid_in=0 do not count.
- **DONE:** capture frozen. rd_ptr starts at the oldest entry: wr_ptr if wrapped, else 0.
  - Each rd_req returns the next entry in order.
  - After the entry with rd_last is returned, state → IDLE.
  - rd_req with nothing remaining is ignored.
- **Arm in any state:** restarts capture exactly as from IDLE, discarding the current window. This includes an arm during readout.
- **rd_req outside DONE:** ignored; rd_valid stays 0.
- **trig_pos:** equals entries−1−post_count_latched, evaluated at DONE. Because post_count ≤ DEPTH-1, it is always ≥0.

## Timing
- **Reset values:** on rst, all of the following take effect the next edge:
  - state=IDLE, rd_valid=0, rd_last=0, rd_data=0, entries=0, trig_pos=0, wrapped=0, ts=0.
  - Buffer RAM is not cleared.
- **Capture:** a sample presented in cycle N is written on edge N. The state transition caused by a trigger in cycle N is visible at N+1.
- **Arm:** arm at edge N gives state=ARMED at N+1. A sample valid in the same cycle as arm is not captured.
- **Readout latency:** rd_req at edge N gives rd_valid=1 with rd_data and rd_last during cycle N+1. Back-to-back rd_req yields one entry per cycle.
- **Final entry:** state=IDLE in the cycle after rd_last is asserted.
- **Reset mid-readout:** rst has priority over arm, rd_req and capture in the same cycle. Any pending rd_valid is dropped.

## Test plan
- **Reset:** drive rst for 2 cycles with random inputs. Expect state=0, rd_valid=0, entries=0, wrapped=0, rd_data=0.
- **No wrap:** DEPTH=64, arm, trig_mask=0x04, trig_value=0x04, post_count=3. Drive 10 valid samples with evt bit2 set only on sample 5. Expect:
  - DONE after sample 8; entries=9, trig_pos=5, wrapped=0.
  - Readout returns pc 0..8 in order, with rd_last on the 9th entry.
- **Wrap:** arm, 100 valid samples with no trigger, then a trigger on sample 100, post_count=10. Expect:
  - entries=64, wrapped=1, trig_pos=53.
  - First read pc=47, last read pc=110.
- **Gapped post-trigger:** post_count=0, with valid_in toggling 1/0 across the trigger cycle. Expect DONE the cycle after the trigger, and the trigger sample to be the last entry. A separate run with post_count=4 and interleaved valid_in=0 cycles shows only valid samples being counted.
- **Re-arm mid-readout:** read 3 entries, then pulse arm together with rd_req. Expect:
  - No rd_valid in the next cycle; state=ARMED, entries=0.
  - A new capture then completes normally.
- **Reset mid-POST:** with state=POST, assert rst. Expect state=IDLE next cycle. A following arm/trigger run gives fresh timestamps starting from 0 after reset.
